// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM pipeline stage: data-memory access, branch resolve, MEM/WB register
//
// Purpose:
//   Takes the EX/MEM pipeline register outputs, performs a word-sized
//   data-memory access over a req/ack bus, resolves the branch decision and
//   drives the MEM/WB pipeline register. While an access is outstanding the
//   stage asserts stall_o so every upstream register holds. Misaligned
//   accesses are dropped and turned into a bubble. Accesses that wait longer
//   than DMEM_TIMEOUT cycles are abandoned and raise a sticky bus error.
//
// Parameters:
//   DMEM_TIMEOUT    max cycles spent in WAIT without an ack (2..255)
//
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   *_MEMORYACCESS                  EX/MEM register fields (inputs)
//   PCSrc_o, PCTarget_o             branch decision and target (combinational)
//   stall_o                         hold upstream pipeline registers
//   dmem_req_o/we_o/addr_o/wdata_o  data-memory request side
//   dmem_ack_i, dmem_rdata_i        data-memory response side
//   *_WRITEBACK                     MEM/WB register fields (registered)
//   misaligned_o                    one-cycle pulse, misaligned op dropped
//   bus_error_o                     sticky, set when an access times out

module memory_access_stage #(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic [31:0] PCTarget_MEMORYACCESS,
    input  logic        zero_MEMORYACCESS,
    input  logic [31:0] ALUResult_MEMORYACCESS,
    input  logic [31:0] ReadData2_MEMORYACCESS,
    input  logic [4:0]  Write_Register_MEMORYACCESS,
    input  logic        MemtoReg_MEMORYACCESS,
    input  logic        MemWrite_MEMORYACCESS,
    input  logic        MemRead_MEMORYACCESS,
    input  logic        RegWrite_MEMORYACCESS,
    input  logic        Branch_MEMORYACCESS,

    output logic        PCSrc_o,
    output logic [31:0] PCTarget_o,
    output logic        stall_o,

    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,

    output logic [31:0] ReadData_WRITEBACK,
    output logic [31:0] ALUResult_WRITEBACK,
    output logic [4:0]  Write_Register_WRITEBACK,
    output logic        MemtoReg_WRITEBACK,
    output logic        RegWrite_WRITEBACK,

    output logic        misaligned_o,
    output logic        bus_error_o
);

    localparam int CW = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(DMEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_count;

    logic        w_memop;
    logic        w_aligned;
    logic        w_misaligned;
    logic        w_req;
    logic        w_abandon;
    logic        w_stall;
    logic        w_complete;
    logic        w_complete_read;
    logic        w_bubble;

    logic [31:0] r_read_data;
    logic [31:0] r_alu_result;
    logic [4:0]  r_write_register;
    logic        r_memtoreg;
    logic        r_regwrite;
    logic        r_misaligned;
    logic        r_bus_error;

    assign w_memop   = MemRead_MEMORYACCESS | MemWrite_MEMORYACCESS;
    assign w_aligned = (ALUResult_MEMORYACCESS[1:0] == 2'b00);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req && !dmem_ack_i) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_ack_i || w_abandon) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // In WAIT the request fields come straight from the EX/MEM inputs; they
    // cannot move because upstream is held by stall_o.
    // ------------------------------------------------------------------
    always_comb begin
        w_req        = 1'b0;
        w_abandon    = 1'b0;
        w_misaligned = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req        = w_memop & w_aligned;
                w_misaligned = w_memop & ~w_aligned;
            end
            S_WAIT: begin
                w_req     = 1'b1;
                w_abandon = ~dmem_ack_i & (r_count == TIMEOUT_VAL);
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    // Timeout counter: 1 on entry to WAIT, counts up each waiting cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_count <= (w_req && !dmem_ack_i) ? CNT_ONE : '0;
                S_WAIT: r_count <= (dmem_ack_i || w_abandon) ? '0 : r_count + CNT_ONE;
                default: r_count <= '0;
            endcase
        end
    end

    // Stall is combinational so upstream advances on the very edge that
    // completes (or abandons) the access; the op is never reissued.
    assign w_stall         = w_req & ~dmem_ack_i & ~w_abandon;
    assign w_complete      = w_req & dmem_ack_i;
    assign w_complete_read = w_complete & ~MemWrite_MEMORYACCESS;
    assign w_bubble        = w_stall | w_misaligned | w_abandon;

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_read_data      <= '0;
            r_alu_result     <= '0;
            r_write_register <= '0;
            r_memtoreg       <= 1'b0;
            r_regwrite       <= 1'b0;
        end else begin
            r_read_data <= w_complete_read ? dmem_rdata_i : 32'h0;
            if (w_bubble) begin
                // Only the control bits matter for a bubble; data fields hold.
                r_memtoreg <= 1'b0;
                r_regwrite <= 1'b0;
            end else begin
                r_alu_result     <= ALUResult_MEMORYACCESS;
                r_write_register <= Write_Register_MEMORYACCESS;
                r_memtoreg       <= MemtoReg_MEMORYACCESS;
                r_regwrite       <= RegWrite_MEMORYACCESS;
            end
        end
    end

    // Status flags
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_misaligned <= w_misaligned;
            if (w_abandon) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign PCSrc_o    = Branch_MEMORYACCESS & zero_MEMORYACCESS;
    assign PCTarget_o = PCTarget_MEMORYACCESS;
    assign stall_o    = w_stall;

    assign dmem_req_o   = w_req;
    assign dmem_we_o    = MemWrite_MEMORYACCESS;
    assign dmem_addr_o  = {ALUResult_MEMORYACCESS[31:2], 2'b00};
    assign dmem_wdata_o = ReadData2_MEMORYACCESS;

    assign ReadData_WRITEBACK       = r_read_data;
    assign ALUResult_WRITEBACK      = r_alu_result;
    assign Write_Register_WRITEBACK = r_write_register;
    assign MemtoReg_WRITEBACK       = r_memtoreg;
    assign RegWrite_WRITEBACK       = r_regwrite;

    assign misaligned_o = r_misaligned;
    assign bus_error_o  = r_bus_error;

endmodule
